// File: rtl/interval_timer_mc_pkg.sv
// Interval timer shared definitions: register offsets,
// STATUS/CONTROL bit positions and the per-channel flag bundle.
package interval_timer_mc_pkg;

  localparam logic [2:0] OFF_STATUS   = 3'd0;
  localparam logic [2:0] OFF_CONTROL  = 3'd1;
  localparam logic [2:0] OFF_PERIOD   = 3'd2;
  localparam logic [2:0] OFF_SNAP     = 3'd3;
  localparam logic [2:0] OFF_PRESCALE = 3'd4;

  localparam int ST_TO    = 0;
  localparam int ST_RUN   = 1;
  localparam int CT_ITO   = 0;
  localparam int CT_CONT  = 1;
  localparam int CT_START = 2;
  localparam int CT_STOP  = 3;

  typedef struct packed {
    logic run;
    logic to;
    logic cont;
    logic ito;
  } ch_flags_t;

endpackage

// File: rtl/interval_timer_ch.sv
// One timer channel: counter, optional prescaler, RUN/TO, CONTROL,
// PERIOD, SNAP. Ports: clk, reset, wr_en/offset/wdata, field outputs.
// Prescaler enabled by INTERVAL_TIMER_MC_PRESCALER_EN.
module interval_timer_ch
  import interval_timer_mc_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int RESET_PERIOD = 9999,
  parameter int PRE_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [2:0]       offset,
  input  logic [31:0]      wdata,
  output ch_flags_t        flags,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] snap,
  output logic [PRE_W-1:0] prescale,
  output logic             irq
);

  localparam logic [CNT_W-1:0] RST_P =
    CNT_W'(RESET_PERIOD);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] snap_q, snap_d;
  logic             run_q, run_d;
  logic             to_q, to_d;
  logic             cont_q, cont_d;
  logic             ito_q, ito_d;
  logic             tick;
  logic             expire;

  logic wr_status, wr_ctrl, wr_period;
  logic wr_snap, wr_pre, start, stop;

  assign wr_status = wr_en && offset == OFF_STATUS;
  assign wr_ctrl   = wr_en && offset == OFF_CONTROL;
  assign wr_period = wr_en && offset == OFF_PERIOD;
  assign wr_snap   = wr_en && offset == OFF_SNAP;
  assign wr_pre    = wr_en && offset == OFF_PRESCALE;
  assign start     = wr_ctrl && wdata[CT_START];
  assign stop      = wr_ctrl && wdata[CT_STOP];

`ifdef INTERVAL_TIMER_MC_PRESCALER_EN
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [PRE_W-1:0] pcnt_q, pcnt_d;

  // >= rather than == so a shrinking PRESCALE
  // cannot strand the phase counter above it.
  assign tick     = run_q && (pcnt_q >= pre_q);
  assign prescale = pre_q;

  always_comb begin
    pre_d  = pre_q;
    pcnt_d = pcnt_q;
    if (run_q)
      pcnt_d = tick ? '0 : pcnt_q + 1'b1;
    if (start || wr_period)
      pcnt_d = '0;
    if (wr_pre)
      pre_d = wdata[PRE_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q  <= '0;
      pcnt_q <= '0;
    end else begin
      pre_q  <= pre_d;
      pcnt_q <= pcnt_d;
    end
  end
`else
  assign tick     = run_q;
  assign prescale = '0;
`endif

  assign expire = tick && (cnt_q == '0);

  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    snap_d   = snap_q;
    run_d    = run_q;
    to_d     = to_q;
    cont_d   = cont_q;
    ito_d    = ito_q;
    if (expire) begin
      to_d  = 1'b1;
      cnt_d = period_q;
      run_d = cont_q;
    end else if (tick) begin
      cnt_d = cnt_q - 1'b1;
    end
    // An expiry in the same cycle beats the clear.
    if (wr_status && !expire)
      to_d = 1'b0;
    if (wr_ctrl) begin
      cont_d = wdata[CT_CONT];
      ito_d  = wdata[CT_ITO];
    end
    if (start)
      run_d = 1'b1;
    else if (stop)
      run_d = 1'b0;
    if (wr_period) begin
      period_d = wdata[CNT_W-1:0];
      cnt_d    = wdata[CNT_W-1:0];
      run_d    = 1'b0;
    end
    if (wr_snap)
      snap_d = cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= RST_P;
      period_q <= RST_P;
      snap_q   <= '0;
      run_q    <= 1'b0;
      to_q     <= 1'b0;
      cont_q   <= 1'b0;
      ito_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      snap_q   <= snap_d;
      run_q    <= run_d;
      to_q     <= to_d;
      cont_q   <= cont_d;
      ito_q    <= ito_d;
    end
  end

  assign flags.run  = run_q;
  assign flags.to   = to_q;
  assign flags.cont = cont_q;
  assign flags.ito  = ito_q;
  assign period     = period_q;
  assign snap       = snap_q;
  assign irq        = to_q & ito_q;

endmodule

// File: rtl/interval_timer_mc.sv
// Multi-channel interval timer: address decode, channel array,
// registered read mux. Ports: clk, reset, bus slave, irq, irq_vec.
// Optional prescaler: INTERVAL_TIMER_MC_PRESCALER_EN.
module interval_timer_mc
  import interval_timer_mc_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int RESET_PERIOD = 9999,
  parameter int PRE_W        = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [$clog2(NUM_CH)+2:0]   address,
  input  logic                        chipselect,
  input  logic                        write_n,
  input  logic [31:0]                 writedata,
  output logic [31:0]                 readdata,
  output logic                        irq,
  output logic [NUM_CH-1:0]           irq_vec
);

  logic [31:0] ch_idx;
  logic [2:0]  offset;
  logic        wr;

  assign ch_idx = 32'(address >> 3);
  assign offset = address[2:0];
  assign wr     = chipselect & ~write_n;

  ch_flags_t        flags  [NUM_CH];
  logic [CNT_W-1:0] period [NUM_CH];
  logic [CNT_W-1:0] snap   [NUM_CH];
  logic [PRE_W-1:0] pre    [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    interval_timer_ch #(
      .CNT_W        (CNT_W),
      .RESET_PERIOD (RESET_PERIOD),
      .PRE_W        (PRE_W)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr && ch_idx == 32'(i)),
      .offset   (offset),
      .wdata    (writedata),
      .flags    (flags[i]),
      .period   (period[i]),
      .snap     (snap[i]),
      .prescale (pre[i]),
      .irq      (irq_vec[i])
    );
  end

  assign irq = |irq_vec;

  logic [31:0] readdata_q, readdata_d;

  // Out-of-range channels match no loop index and read 0.
  always_comb begin
    readdata_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_idx == 32'(i)) begin
        unique case (offset)
          OFF_STATUS: begin
            readdata_d[ST_RUN] = flags[i].run;
            readdata_d[ST_TO]  = flags[i].to;
          end
          OFF_CONTROL: begin
            readdata_d[CT_CONT] = flags[i].cont;
            readdata_d[CT_ITO]  = flags[i].ito;
          end
          OFF_PERIOD:   readdata_d = 32'(period[i]);
          OFF_SNAP:     readdata_d = 32'(snap[i]);
          OFF_PRESCALE: readdata_d = 32'(pre[i]);
          default:      readdata_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      readdata_q <= '0;
    else
      readdata_q <= readdata_d;
  end

  assign readdata = readdata_q;

endmodule

// File: tb/tb_interval_timer_mc.sv
// Bench for interval_timer_mc: directed steps plus random bus
// traffic, checked each cycle against a behavioural channel model.
module tb_interval_timer_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic [3:0]  irq_vec;

  int ncmp = 0;
  int nfail = 0;

  interval_timer_mc dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .irq_vec    (irq_vec)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  logic [31:0] m_cnt [4];
  logic [31:0] m_per [4];
  logic [31:0] m_snap[4];
  logic [31:0] m_pre [4];
  int          m_ph  [4];
  bit          m_run [4];
  bit          m_to  [4];
  bit          m_cont[4];
  bit          m_ito [4];

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = 9999; m_per[i] = 9999;
      m_snap[i] = 0; m_pre[i] = 0; m_ph[i] = 0;
      m_run[i] = 0; m_to[i] = 0;
      m_cont[i] = 0; m_ito[i] = 0;
    end
  endfunction

  function automatic logic [3:0] m_vec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_to[i] & m_ito[i];
    return v;
  endfunction

  function automatic logic [31:0] exp_rd(logic [4:0] a);
    int c;
    c = int'(a[4:3]);
    case (a[2:0])
      3'd0: return {30'd0, m_run[c], m_to[c]};
      3'd1: return {30'd0, m_cont[c], m_ito[c]};
      3'd2: return m_per[c];
      3'd3: return m_snap[c];
`ifdef INTERVAL_TIMER_MC_PRESCALER_EN
      3'd4: return m_pre[c];
`endif
      default: return 32'd0;
    endcase
  endfunction

  // One clock of every channel: optional prescale, then count
  // or expire, then the effect of a bus write to that channel.
  function automatic void model_step(bit wr, logic [4:0] a,
                                     logic [31:0] d);
    for (int i = 0; i < 4; i++) begin
      bit tick;
      bit ex;
      logic [31:0] old_cnt;
      old_cnt = m_cnt[i];
`ifdef INTERVAL_TIMER_MC_PRESCALER_EN
      tick = m_run[i] && (m_ph[i] >= int'(m_pre[i]));
      if (m_run[i]) m_ph[i] = tick ? 0 : m_ph[i] + 1;
`else
      tick = m_run[i];
`endif
      ex = tick && (m_cnt[i] == 0);
      if (ex) begin
        m_to[i] = 1; m_cnt[i] = m_per[i]; m_run[i] = m_cont[i];
      end else if (tick) begin
        m_cnt[i] = m_cnt[i] - 1;
      end
      if (wr && int'(a[4:3]) == i) begin
        case (a[2:0])
          3'd0: if (!ex) m_to[i] = 0;
          3'd1: begin
            m_cont[i] = d[1]; m_ito[i] = d[0];
            if (d[2]) begin m_run[i] = 1; m_ph[i] = 0; end
            else if (d[3]) m_run[i] = 0;
          end
          3'd2: begin
            m_per[i] = d; m_cnt[i] = d;
            m_run[i] = 0; m_ph[i] = 0;
          end
          3'd3: m_snap[i] = old_cnt;
`ifdef INTERVAL_TIMER_MC_PRESCALER_EN
          3'd4: m_pre[i] = {16'd0, d[15:0]};
`endif
          default: ;
        endcase
      end
    end
  endfunction

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc(bit wr, logic [4:0] a, logic [31:0] d);
    logic [31:0] erd;
    if (wr) begin
      chipselect = 1'b1; write_n = 1'b0;
    end else begin
      chipselect = 1'($urandom_range(0, 1));
      write_n = chipselect ? 1'b1 : 1'($urandom_range(0, 1));
    end
    address = a;
    writedata = d;
    erd = exp_rd(a);
    @(posedge clk);
    model_step(wr, a, d);
    #1;
    chk("readdata", readdata, erd);
    chk("irq_vec", {28'd0, irq_vec}, {28'd0, m_vec()});
    chk("irq", {31'd0, irq}, {31'd0, |m_vec()});
  endtask

  function automatic logic [4:0] ad(int c, int o);
    return 5'((c << 3) | o);
  endfunction

  task automatic wr_reg(int c, int o, logic [31:0] d);
    cyc(1'b1, ad(c, o), d);
  endtask

  task automatic rd_reg(int c, int o);
    cyc(1'b0, ad(c, o), $urandom);
  endtask

  task automatic idle();
    cyc(1'b0, 5'($urandom_range(0, 31)), $urandom);
  endtask

  task automatic wait_vec(int b, int max, output int n);
    n = 0;
    do begin
      idle();
      n++;
    end while (!irq_vec[b] && n < max);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    chipselect = 1'b0;
    write_n = 1'b1;
    address = '0;
    writedata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_irq_vec", {28'd0, irq_vec}, 32'd0);
    reset = 1'b0;

    rd_reg(0, 2);
    chk("rst_period", readdata, 32'd9999);
    rd_reg(0, 0);
    chk("rst_status", readdata, 32'd0);

    wr_reg(1, 2, 5);
    wr_reg(1, 1, 7);
    wait_vec(1, 20, n);
    chk("ch1_first_to", n, 6);
    chk("ch1_vec", {28'd0, irq_vec}, 32'h2);
    wr_reg(1, 0, 0);
    wait_vec(1, 20, n);
    chk("ch1_reload", n, 5);
    wr_reg(1, 1, 8);
    wr_reg(1, 0, 0);

    wr_reg(0, 2, 3);
    wr_reg(0, 1, 5);
    wait_vec(0, 20, n);
    chk("ch0_oneshot", n, 4);
    repeat (5) idle();
    rd_reg(0, 0);
    chk("ch0_status", readdata, 32'd1);
    wr_reg(0, 3, 0);
    rd_reg(0, 3);
    chk("ch0_count", readdata, 32'd3);
    wr_reg(0, 0, 0);
    chk("ch0_irq_clr", {31'd0, irq}, 32'd0);

    wr_reg(2, 2, 0);
    wr_reg(2, 1, 7);
    repeat (2) idle();
    wr_reg(2, 0, 0);
    rd_reg(2, 0);
    chk("clr_vs_expiry", readdata, 32'd3);
    wr_reg(2, 1, 8);
    wr_reg(2, 1, 12);
    rd_reg(2, 0);
    chk("start_stop", {31'd0, readdata[1]}, 32'd1);
    wr_reg(2, 1, 8);
    wr_reg(2, 0, 0);

`ifdef INTERVAL_TIMER_MC_PRESCALER_EN
    wr_reg(3, 4, 3);
    wr_reg(3, 2, 1);
    wr_reg(3, 1, 7);
    wait_vec(3, 40, n);
    chk("pre_first", n, 8);
    wr_reg(3, 0, 0);
    wait_vec(3, 40, n);
    chk("pre_next", n, 7);
    wr_reg(3, 1, 8);
    wr_reg(3, 0, 0);
    wr_reg(3, 4, 0);
`else
    wr_reg(3, 4, 5);
    rd_reg(3, 4);
    chk("pre_off", readdata, 32'd0);
`endif

    wr_reg(2, 2, 100);
    wr_reg(2, 1, 4);
    repeat (9) idle();
    wr_reg(2, 3, 0);
    rd_reg(2, 3);
    chk("ch2_snap", readdata, 32'd91);
    rd_reg(0, 3);
    chk("ch0_snap_kept", readdata, 32'd3);
    rd_reg(3, 3);
    chk("ch3_snap_kept", readdata, 32'd0);
    wr_reg(2, 1, 8);

    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        int c, o;
        logic [31:0] d;
        c = $urandom_range(0, 3);
        o = $urandom_range(0, 7);
        case (o)
          2: d = $urandom_range(0, 15);
          4: d = $urandom_range(0, 3);
          default: d = $urandom;
        endcase
        wr_reg(c, o, d);
      end else begin
        idle();
      end
    end

    wr_reg(0, 4, 0);
    wr_reg(0, 2, 2);
    wr_reg(0, 0, 0);
    wr_reg(0, 1, 7);
    wait_vec(0, 20, n);
    chk("pre_reset_irq", n, 3);
    wr_reg(0, 2, 50);
    wr_reg(0, 1, 7);
    repeat (3) idle();
    reset = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_rd", readdata, 32'd0);
    chk("mid_rst_irq", {31'd0, irq}, 32'd0);
    chk("mid_rst_vec", {28'd0, irq_vec}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    rd_reg(0, 2);
    chk("post_rst_period", readdata, 32'd9999);
    rd_reg(0, 0);
    chk("post_rst_status", readdata, 32'd0);
    repeat (20) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
